// File: rtl/mesh_router_wormhole_output_arb_pkg.sv
// Shared router types: wormhole arbiter state and the direction indices used
// by the bench and profiler to name req/yumi bits.
package bsg_mesh_router_pkg;

  typedef enum logic {eIdle, eLocked} wh_arb_state_e;

  // Bit positions of req/yumi vectors; RW/RE exist only with ruche links.
  typedef enum logic [2:0] {P = 3'd0, W, E, N, S, RW, RE} dir_e;

endpackage

// File: rtl/mesh_router_wormhole_output_arb_rr_pick.sv
// Rotating priority encoder: first asserted req at or after ptr, wrapping.
// Purely combinational; returns one-hot, index and an any-request flag.
module mesh_rr_pick #(
  parameter  int width_p = 5,
  localparam int ptr_w   = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic [width_p-1:0] req,
  input  logic [ptr_w-1:0]   ptr,
  output logic [width_p-1:0] onehot,
  output logic [ptr_w-1:0]   idx,
  output logic               any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Walk from the farthest offset back to ptr so the nearest hit is written last.
    for (int k = width_p - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= width_p) j = j - width_p;
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = ptr_w'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_router_wormhole_output_arb.sv
// Per-output wormhole scheduler: round-robin on headers, then the port stays
// locked to the winning input until its last body flit has left.
module mesh_router_wormhole_output_arb
  import bsg_mesh_router_pkg::*;
#(
  parameter int dirs_p      = 5,
  parameter int len_width_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [dirs_p-1:0]             req_i,
  input  logic [dirs_p*len_width_p-1:0] len_i,
  input  logic                          ready_i,
  output logic                          v_o,
  output logic [dirs_p-1:0]             sel_o,
  output logic [dirs_p-1:0]             yumi_o,
  output logic                          locked_o
);

  localparam int ptr_w = (dirs_p > 1) ? $clog2(dirs_p) : 1;

  wh_arb_state_e          state_r;
  logic [ptr_w-1:0]       ptr_r, owner_r;
  logic [len_width_p-1:0] cnt_r;
  logic                   pend_r;

  logic [dirs_p-1:0]      pick_oh, win_oh;
  logic [ptr_w-1:0]       pick_idx, winner, winner_inc;
  logic                   pick_any, held, v, xfer;
  logic [len_width_p-1:0] win_len;

  mesh_rr_pick #(.width_p(dirs_p)) pick (
    .req    (req_i),
    .ptr    (ptr_r),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Once a packet is locked or its header is stalled, the choice is frozen on owner_r.
  always_comb begin
    held       = (state_r == eLocked) | pend_r;
    winner     = held ? owner_r : pick_idx;
    win_oh     = '0;
    win_oh[owner_r] = 1'b1;
    if (!held) win_oh = pick_oh;
    v          = (held ? req_i[owner_r] : pick_any) & reset_n_i;
    xfer       = v & ready_i;
    win_len    = len_i[winner*len_width_p +: len_width_p];
    winner_inc = (winner == ptr_w'(dirs_p - 1)) ? '0 : winner + ptr_w'(1);
  end

  assign v_o      = v;
  assign sel_o    = v    ? win_oh : '0;
  assign yumi_o   = xfer ? win_oh : '0;
  assign locked_o = (state_r == eLocked);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eIdle;
      ptr_r   <= '0;
      owner_r <= '0;
      cnt_r   <= '0;
      pend_r  <= 1'b0;
    end else begin
      case (state_r)
        eIdle: begin
          if (xfer) begin
            pend_r <= 1'b0;
            if (win_len == '0) begin
              ptr_r <= winner_inc;
            end else begin
              state_r <= eLocked;
              owner_r <= winner;
              cnt_r   <= win_len;
            end
          end else if (v) begin
            pend_r  <= 1'b1;
            owner_r <= winner;
          end
        end
        eLocked: begin
          if (xfer && cnt_r != '0) begin
            cnt_r <= cnt_r - len_width_p'(1);
            // Tail leaves: next header is picked next cycle from the advanced pointer.
            if (cnt_r == len_width_p'(1)) begin
              state_r <= eIdle;
              ptr_r   <= winner_inc;
            end
          end
        end
        default: state_r <= eIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ($onehot0(yumi_o)) else $error("arb: yumi_o not onehot0");
      assert ($onehot0(sel_o))  else $error("arb: sel_o not onehot0");
      assert (!(pend_r && !req_i[owner_r])) else $error("arb: stalled header request dropped");
      assert (!(|yumi_o) || ready_i) else $error("arb: yumi_o without ready_i");
    end
  end
`endif

endmodule

// File: tb/tb_mesh_router_wormhole_output_arb.sv
// Directed scenarios plus random traffic against a packet-level reference
// model (owner, flits remaining, round-robin pointer).
module tb_mesh_router_wormhole_output_arb;

  localparam int D = 5;
  localparam int L = 4;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [D-1:0]   req_i;
  logic [D*L-1:0] len_i;
  logic           ready_i;
  logic           v_o, locked_o;
  logic [D-1:0]   sel_o, yumi_o;

  int checks = 0;
  int errors = 0;

  // reference model: -1 means "none"
  int m_ptr, m_own, m_left, m_pend;
  logic [D-1:0] last_yumi;

  mesh_router_wormhole_output_arb #(.dirs_p(D), .len_width_p(L)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .req_i     (req_i),
    .len_i     (len_i),
    .ready_i   (ready_i),
    .v_o       (v_o),
    .sel_o     (sel_o),
    .yumi_o    (yumi_o),
    .locked_o  (locked_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_own = -1; m_left = 0; m_pend = -1;
  endtask

  // One clock: check outputs at negedge against the model, advance the model,
  // then return just after the posedge so the caller can drive new inputs.
  task automatic cyc(input string tag, input bit den, input logic [D-1:0] dy);
    int w, l;
    logic [D-1:0] es;
    @(negedge clk_i);
    w = -1;
    if (m_own >= 0)       w = req_i[m_own] ? m_own : -1;
    else if (m_pend >= 0) w = m_pend;
    else begin
      for (int k = 0; k < D; k++) begin
        if (w < 0 && req_i[(m_ptr + k) % D]) w = (m_ptr + k) % D;
      end
    end
    es = '0;
    if (w >= 0) es[w] = 1'b1;
    chk({tag, "_v"},      v_o,      32'(w >= 0));
    chk({tag, "_sel"},    sel_o,    es);
    chk({tag, "_yumi"},   yumi_o,   ready_i ? es : '0);
    chk({tag, "_locked"}, locked_o, 32'(m_own >= 0));
    if (den) chk({tag, "_dir"}, yumi_o, dy);
    last_yumi = yumi_o;
    if (w >= 0 && ready_i) begin
      if (m_own >= 0) begin
        m_left--;
        if (m_left == 0) begin m_ptr = (m_own + 1) % D; m_own = -1; end
      end else begin
        m_pend = -1;
        l = int'(len_i[w*L +: L]);
        if (l == 0) m_ptr = (w + 1) % D;
        else begin m_own = w; m_left = l; end
      end
    end else if (w >= 0 && m_own < 0) begin
      m_pend = w;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    req_i = '1; len_i = '0; ready_i = 1'b1;
    #1;
    chk("rst_v", v_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_yumi", yumi_o, 0);
    chk("rst_locked", locked_o, 0);
    req_i = '0; ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    reset_n_i = 1'b1;
  endtask

  initial begin
    int n;
    logic [D-1:0] t1 [4];
    t1[0] = 5'b00010; t1[1] = 5'b00100; t1[2] = 5'b10000; t1[3] = 5'b00010;

    // 1: single-flit round robin with pointer wrap
    do_reset();
    req_i = 5'b10110; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc("t1", 1, t1[i]);

    // 2: len=3 packet from input 1 holds the port against input 3
    do_reset();
    req_i = 5'b01010; len_i[1*L +: L] = 4'd3; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc("t2", 1, 5'b00010);
    len_i = '0;
    cyc("t2_next", 1, 5'b01000);

    // 3: stalled header keeps its selection when a higher-priority req arrives
    do_reset();
    req_i = 5'b00100; ready_i = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t3_stall", 1, 5'b00000);
    req_i = 5'b00101; ready_i = 1'b1;
    cyc("t3_go", 1, 5'b00100);
    req_i = 5'b00001;
    cyc("t3_in0", 1, 5'b00001);

    // 4: owner bubble mid-packet
    do_reset();
    req_i = 5'b10000; len_i[4*L +: L] = 4'd2; ready_i = 1'b1;
    cyc("t4_hdr", 1, 5'b10000);
    req_i = 5'b10011;
    cyc("t4_b1", 1, 5'b10000);
    req_i = 5'b00011;
    for (int i = 0; i < 2; i++) begin
      cyc("t4_gap", 1, 5'b00000);
      chk("t4_cnt", 32'(dut.cnt_r), 1);
    end
    req_i = 5'b10011;
    cyc("t4_tail", 1, 5'b10000);
    len_i = '0;
    cyc("t4_after", 1, 5'b00001);

    // 5: max-length packet, ready toggling
    do_reset();
    req_i = 5'b00001; len_i[0 +: L] = 4'hF;
    n = 0;
    for (int i = 0; i < 64 && n < 16; i++) begin
      ready_i = (i % 2 == 0);
      cyc("t5", 0, '0);
      if (last_yumi[0]) n++;
    end
    req_i = '0; len_i = '0;
    chk("t5_count", n, 16);
    chk("t5_locked", locked_o, 0);
    cyc("t5_idle", 1, 5'b00000);

    // 6: asynchronous reset in the middle of a locked packet
    do_reset();
    req_i = 5'b00001; len_i[0 +: L] = 4'd8; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc("t6", 0, '0);
    chk("t6_cnt_pre", 32'(dut.cnt_r), 5);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("t6_v", v_o, 0);
    chk("t6_sel", sel_o, 0);
    chk("t6_yumi", yumi_o, 0);
    chk("t6_locked", locked_o, 0);
    chk("t6_cnt", 32'(dut.cnt_r), 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    req_i = 5'b11111; len_i = '0;
    cyc("t6_p0", 1, 5'b00001);
    cyc("t6_p1", 1, 5'b00010);

    // random traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      req_i = D'($urandom);
      if (m_pend >= 0) req_i[m_pend] = 1'b1;
      for (int j = 0; j < D; j++)
        len_i[j*L +: L] = ($urandom % 2 == 0) ? 4'd0 : L'($urandom_range(1, 15));
      ready_i = ($urandom % 4) != 0;
      cyc("rnd", 0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
